// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text console controller.
// Geometry defaults match a 1280x800 display drawn with 8x16 glyphs.
package text_console_pkg;

    localparam int COLS_DEF = 160;
    localparam int ROWS_DEF = 50;
    localparam int CELLS    = COLS_DEF * ROWS_DEF;

    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_BS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PUT      = 2'd1,
        ST_CLR_LINE = 2'd2,
        ST_CLR_ALL  = 2'd3
    } state_e;

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character stream, text RAM write port and cursor/scroll status of the console.
// The master side feeds characters and vblank; the slave side is the controller.
interface text_console_ctrl_if;

    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        clear_req;
    logic        vblank;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  scroll_base;
    logic [7:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    modport master (
        output char_valid, char_data, clear_req, vblank,
        input  char_ready, wr_en, wr_addr, wr_data,
        input  scroll_base, cursor_col, cursor_row, busy
    );

    modport slave (
        input  char_valid, char_data, clear_req, vblank,
        output char_ready, wr_en, wr_addr, wr_data,
        output scroll_base, cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/text_addr_calc.sv
// Maps a logical screen row onto its physical text RAM row and cell address.
// The modulo is a single compare-and-subtract since both operands are below ROWS.
module text_addr_calc #(
    parameter int ROWS = 50
) (
    input  logic [5:0]  scroll_base,
    input  logic [5:0]  row,
    input  logic [7:0]  col,
    output logic [12:0] addr
);

    logic [6:0] row_sum;
    logic [5:0] phys_row;

    // Row stride of 160 cells is built as 128 + 32 to avoid a multiplier.
    always_comb begin
        row_sum = {1'b0, scroll_base} + {1'b0, row};
        if (row_sum >= 7'(ROWS)) begin
            phys_row = 6'(row_sum - 7'(ROWS));
        end else begin
            phys_row = row_sum[5:0];
        end
        addr = {phys_row, 7'b0} + {2'b0, phys_row, 5'b0} + {5'b0, col};
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Turns an ASCII character stream into text RAM writes, handling cursor motion,
// hardware scrolling via scroll_base and full-screen clears inside vblank only.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    text_console_ctrl_if.slave  bus
);

    localparam int         NCELLS   = COLS * ROWS;
    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] PUT      = ST_PUT;
    localparam logic [1:0] CLR_LINE = ST_CLR_LINE;
    localparam logic [1:0] CLR_ALL  = ST_CLR_ALL;

    logic [1:0]  state;
    logic [7:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [5:0]  scroll_base;
    logic        clr_pending;
    logic [7:0]  clr_col;
    logic [12:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    logic        char_ready;
    logic        accept;
    logic        printable;
    logic        last_col;
    logic        at_bottom;
    logic        newline;
    logic        use_cursor;
    logic [5:0]  sb_next;
    logic [5:0]  calc_row;
    logic [7:0]  calc_col;
    logic [12:0] calc_addr;

    // Row 0 of the current scroll_base is exactly the physical row that becomes
    // the new bottom line after a scroll, so newline requests steer the shared
    // address calculator there; printable characters use the live cursor.
    always_comb begin
        char_ready = reset && (state == IDLE) && !clr_pending && !bus.clear_req;
        accept     = bus.char_valid && char_ready;
        printable  = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);
        last_col   = (cursor_col == 8'(COLS - 1));
        at_bottom  = (cursor_row == 6'(ROWS - 1));
        sb_next    = (scroll_base == 6'(ROWS - 1)) ? 6'd0 : scroll_base + 6'd1;
        newline    = ((state == IDLE) && accept && (bus.char_data == CODE_LF)) ||
                     ((state == PUT) && bus.vblank && last_col);
        use_cursor = (state == IDLE) && (bus.char_data != CODE_LF);
        calc_row   = use_cursor ? cursor_row : 6'd0;
        calc_col   = use_cursor ? cursor_col : 8'd0;
    end

    text_addr_calc #(
        .ROWS (ROWS)
    ) u_addr_calc (
        .scroll_base (scroll_base),
        .row         (calc_row),
        .col         (calc_col),
        .addr        (calc_addr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cursor_col  <= '0;
            cursor_row  <= '0;
            scroll_base <= '0;
            clr_pending <= 1'b0;
            clr_col     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if (bus.clear_req && (state != IDLE)) begin
                clr_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.clear_req || clr_pending) begin
                        state       <= CLR_ALL;
                        clr_pending <= 1'b0;
                        wr_addr_q   <= '0;
                        wr_data_q   <= SPACE;
                    end else if (accept) begin
                        if (printable) begin
                            state     <= PUT;
                            wr_addr_q <= calc_addr;
                            wr_data_q <= bus.char_data;
                        end else if (bus.char_data == CODE_CR) begin
                            cursor_col <= '0;
                        end else if ((bus.char_data == CODE_BS) && (cursor_col != 8'd0)) begin
                            cursor_col <= cursor_col - 8'd1;
                        end
                    end
                end
                PUT: begin
                    if (bus.vblank) begin
                        state      <= IDLE;
                        cursor_col <= last_col ? 8'd0 : cursor_col + 8'd1;
                    end
                end
                CLR_LINE: begin
                    if (bus.vblank) begin
                        if (clr_col == 8'(COLS - 1)) begin
                            state <= IDLE;
                        end else begin
                            clr_col   <= clr_col + 8'd1;
                            wr_addr_q <= wr_addr_q + 13'd1;
                        end
                    end
                end
                CLR_ALL: begin
                    if (bus.vblank) begin
                        if (wr_addr_q == 13'(NCELLS - 1)) begin
                            state       <= IDLE;
                            cursor_col  <= '0;
                            cursor_row  <= '0;
                            scroll_base <= '0;
                        end else begin
                            wr_addr_q <= wr_addr_q + 13'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (newline) begin
                if (!at_bottom) begin
                    cursor_row <= cursor_row + 6'd1;
                    state      <= IDLE;
                end else begin
                    scroll_base <= sb_next;
                    clr_col     <= '0;
                    wr_addr_q   <= calc_addr;
                    wr_data_q   <= SPACE;
                    state       <= CLR_LINE;
                end
            end
        end
    end

    assign bus.char_ready  = char_ready;
    assign bus.wr_en       = reset && bus.vblank && (state != IDLE);
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.scroll_base = scroll_base;
    assign bus.cursor_col  = cursor_col;
    assign bus.cursor_row  = cursor_row;
    assign bus.busy        = (state != IDLE) || clr_pending;

endmodule
